temp_display_ctrl: RTL and testbench
====================================

# temp_display_ctrl

Sequencer and display scanner for the temperature readout. On a sample request it captures a 5-bit temperature, splits it into tens and units with a multi-cycle repeated-subtraction FSM, and commits the result atomically. It then drives the two rightmost digits of the board's 4-digit common-anode 7-segment display by time-multiplexing. It sits between the temperature source and the display pins and replaces a purely combinational split.

## Interface

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- temp_in  in  5  temperature in °C, unsigned, 0..31, all codes legal
- sample  in  1  single-cycle request to capture temp_in
- busy  out  1  conversion in progress; sample ignored while high
- valid  out  1  one-cycle pulse: uni/dec just updated
- uni  out  4  committed units digit, 0..9
- dec  out  2  committed tens digit, 0..3
- an  out  4  digit anodes, active-low; an[0] = units, an[1] = tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation

- Reset behaviour: state IDLE; work = 0, tcnt = 0, uni = 0, dec = 0, busy = 0, valid = 0; prescaler = 0, digit select = 0, an = 4'b1110, seg = 7'b1000000 (the "0" glyph).
- FSM states are IDLE and SUB.
- IDLE: when sample = 1, latch work ← temp_in, tcnt ← 0, busy ← 1, and go to SUB. Otherwise hold.
- SUB, work ≥ 10: work ← work − 10 and tcnt ← tcnt + 1, using 5-bit unsigned arithmetic with no underflow possible. Stay in SUB.
- SUB, work < 10: commit uni ← work[3:0] and dec ← tcnt[1:0], valid ← 1, busy ← 0, and go to IDLE.
- sample is ignored while in SUB; no queueing and no restart.
- temp_in is sampled only at capture; later changes do not affect a conversion in flight.
- uni and dec change only at commit, so the display never shows intermediate values.
- Display scanner runs free and independently of the FSM:
  - prescaler counts 0..SCAN_DIV−1 and wraps.
  - At the wrap cycle, digit select toggles.
  - sel = 0: an = 1110, seg = glyph(uni).
  - sel = 1: an = 1101, seg = glyph(dec), except seg = 7'b1111111 (blank) when dec = 0 (leading-zero blanking).
  - an[3:2] are always 1.
- Glyphs (gfedcba, active-low): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- an and seg are registered, so they update one cycle after sel or uni/dec change.

## Timing

- Let sample be high in cycle t and let D = floor(temp_in / 10).
- busy is high in cycles t+1 .. t+D+1.
- valid is high in exactly cycle t+D+2, and uni/dec show the new values from cycle t+D+2.
- Latency is therefore 2..5 cycles (temp 0 → 2, temp 31 → 5).
- In the valid cycle the FSM is already in IDLE, so a sample asserted in that same cycle is accepted. Back-to-back throughput is D+2 cycles per conversion.
- A new commit reaches an/seg one cycle after uni/dec change.
- Digit period is SCAN_DIV cycles, and the full refresh period is 2·SCAN_DIV.
- After reset, sel first toggles at cycle SCAN_DIV−1 after reset deasserts; an changes the cycle after that.
- Reset mid-conversion aborts it: the FSM returns to IDLE, uni/dec go to 0, no valid pulse is issued, and busy = 0 in the cycle after reset.
- If reset and sample are high in the same cycle, reset wins and the sample is dropped.

## Test plan

- Reset, then temp_in = 0 with sample → valid two cycles later; uni = 0, dec = 0; busy high for 1 cycle; tens digit blank.
- temp_in = 31, sample at t → busy high t+1..t+4, valid at t+5, uni = 1, dec = 3; seg shows 1111001 and 0110000 on alternating digits.
- Sweep temp_in 0..31, waiting for valid each time → uni = temp % 10 and dec = temp / 10 for every value, with latency floor(temp/10)+2.
- temp_in = 25 sampled, then sample pulsed with temp_in = 7 during busy → single valid, uni = 5, dec = 2; the second request is ignored. Pulsing sample in the valid cycle starts a new conversion.
- SCAN_DIV = 4, committed value 19 → an alternates between 1110 and 1101 every 4 cycles; seg = 0010000 (9) and 1111001 (1). Committed value 9 → tens digit seg = 1111111.
- temp_in = 30 sampled, reset asserted at t+2 → no valid pulse; uni = 0, dec = 0, busy = 0, an = 1110, seg = 1000000 after reset.

Source files
------------

// File: rtl/temp_display_ctrl.sv
// Temperature sample sequencer: splits a 5-bit reading into tens/units by repeated
// subtraction, commits atomically, and time-multiplexes two 7-segment digits.
module temp_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] temp_in,
    input  logic       sample,
    output logic       busy,
    output logic       valid,
    output logic [3:0] uni,
    output logic [1:0] dec,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SUB  = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [0:0]    state_q, state_d;
    logic [4:0]    work_q,  work_d;
    logic [1:0]    tcnt_q,  tcnt_d;
    logic [3:0]    uni_q,   uni_d;
    logic [1:0]    dec_q,   dec_d;
    logic          busy_q,  busy_d;
    logic          valid_q, valid_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sel_q,   sel_d;
    logic [3:0]    an_q,    an_d;
    logic [6:0]    seg_q,   seg_d;
    logic          wrap_c;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Conversion FSM: capture, subtract tens, commit uni/dec together
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        tcnt_d  = tcnt_q;
        uni_d   = uni_q;
        dec_d   = dec_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample) begin
                    work_d  = temp_in;
                    tcnt_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (work_q >= 5'd10) begin
                    work_d = work_q - 5'd10;
                    tcnt_d = tcnt_q + 2'd1;
                end else begin
                    uni_d   = work_q[3:0];
                    dec_d   = tcnt_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free-running scanner; tens digit blanked when zero
    always_comb begin
        wrap_c  = (presc_q == PW'(SCAN_DIV - 1));
        presc_d = wrap_c ? '0 : presc_q + PW'(1);
        sel_d   = sel_q ^ wrap_c;
        if (sel_q) begin
            an_d  = 4'b1101;
            seg_d = (dec_q == 2'd0) ? SEG_BLANK : glyph({2'b00, dec_q});
        end else begin
            an_d  = 4'b1110;
            seg_d = glyph(uni_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            tcnt_q  <= '0;
            uni_q   <= '0;
            dec_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            presc_q <= '0;
            sel_q   <= 1'b0;
            an_q    <= 4'b1110;
            seg_q   <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            tcnt_q  <= tcnt_d;
            uni_q   <= uni_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign uni   = uni_q;
    assign dec   = dec_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Directed self-checking bench for temp_display_ctrl with a short scan period.
module tb_temp_display_ctrl;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] temp_in;
    logic       sample;
    logic       busy;
    logic       valid;
    logic [3:0] uni;
    logic [1:0] dec;
    logic [3:0] an;
    logic [6:0] seg;

    int n_chk  = 0;
    int n_fail = 0;

    temp_display_ctrl #(.SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .temp_in(temp_in), .sample(sample),
        .busy(busy), .valid(valid), .uni(uni), .dec(dec), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int exp_glyph(input int d);
        int tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one sample and follow it to the valid pulse, checking busy and latency
    task automatic do_conv(input int t);
        bit done = 0;
        temp_in = 5'(t);
        sample  = 1'b1;
        for (int k = 1; k <= 8 && !done; k++) begin
            step();
            if (k == 1) sample = 1'b0;
            if (valid) begin
                check_eq("latency", k, t / 10 + 2);
                check_eq("uni", int'(uni), t % 10);
                check_eq("dec", int'(dec), t / 10);
                check_eq("busy_at_valid", int'(busy), 0);
                done = 1;
            end else begin
                check_eq("busy_during", int'(busy), 1);
            end
        end
        if (!done) check_eq("valid_timeout", 0, 1);
    endtask

    // Watch the scanner for a while: glyph per digit and 4-cycle dwell
    task automatic disp_check(input int useg, input int tseg);
        logic [3:0] prev;
        int last = -1;
        for (int i = 0; i < 3; i++) step();
        prev = an;
        for (int c = 0; c < 20; c++) begin
            step();
            if (an == 4'b1110) begin
                check_eq("seg_units", int'(seg), useg);
            end else begin
                check_eq("an_tens", int'(an), 4'b1101);
                check_eq("seg_tens", int'(seg), tseg);
            end
            if (an != prev) begin
                if (last >= 0) check_eq("digit_period", c - last, SD);
                last = c;
                prev = an;
            end
        end
        if (last < 0) check_eq("an_toggles", 0, 1);
    endtask

    initial begin
        int nv;
        reset   = 1'b1;
        sample  = 1'b0;
        temp_in = 5'd0;
        step();
        step();
        reset = 1'b0;
        check_eq("rst_busy",  int'(busy),  0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_uni",   int'(uni),   0);
        check_eq("rst_dec",   int'(dec),   0);
        check_eq("rst_an",    int'(an),    4'b1110);
        check_eq("rst_seg",   int'(seg),   7'b1000000);

        do_conv(0);
        disp_check(exp_glyph(0), 7'h7F);

        do_conv(31);
        disp_check(exp_glyph(1), exp_glyph(3));

        for (int t = 0; t < 32; t++) do_conv(t);

        do_conv(19);
        disp_check(exp_glyph(9), exp_glyph(1));
        do_conv(9);
        disp_check(exp_glyph(9), 7'h7F);

        // Second request during busy is dropped
        temp_in = 5'd25;
        sample  = 1'b1;
        step();
        temp_in = 5'd7;
        step();
        sample  = 1'b0;
        nv = 0;
        for (int k = 2; k < 12; k++) begin
            if (valid) begin
                nv++;
                check_eq("ign_uni", int'(uni), 5);
                check_eq("ign_dec", int'(dec), 2);
            end
            step();
        end
        check_eq("ign_valid_count", nv, 1);

        // Sample in the valid cycle starts the next conversion
        temp_in = 5'd13;
        sample  = 1'b1;
        step();
        sample  = 1'b0;
        nv = 0;
        for (int k = 0; k < 8 && !valid; k++) step();
        check_eq("b2b_first_valid", int'(valid), 1);
        check_eq("b2b_first_uni",   int'(uni),   3);
        temp_in = 5'd4;
        sample  = 1'b1;
        step();
        sample  = 1'b0;
        check_eq("b2b_busy", int'(busy), 1);
        step();
        check_eq("b2b_valid", int'(valid), 1);
        check_eq("b2b_uni",   int'(uni),   4);
        check_eq("b2b_dec",   int'(dec),   0);

        // Reset mid-conversion aborts without a valid pulse
        do_conv(17);
        for (int i = 0; i < 3; i++) step();
        temp_in = 5'd30;
        sample  = 1'b1;
        step();
        sample  = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_uni",  int'(uni),  0);
        check_eq("abort_dec",  int'(dec),  0);
        check_eq("abort_an",   int'(an),   4'b1110);
        check_eq("abort_seg",  int'(seg),  7'b1000000);
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            if (valid) nv++;
            step();
        end
        check_eq("abort_no_valid", nv, 0);

        // Reset beats a simultaneous sample
        reset   = 1'b1;
        sample  = 1'b1;
        temp_in = 5'd31;
        step();
        reset  = 1'b0;
        sample = 1'b0;
        check_eq("rst_wins_busy0", int'(busy), 0);
        step();
        check_eq("rst_wins_busy1", int'(busy), 0);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            if (valid) nv++;
            step();
        end
        check_eq("rst_wins_no_valid", nv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
